// File: rtl/conv_pool_engine.sv
// 3x3 valid-mode convolution followed by 2x2 stride-2 signed max pooling over a square image.
// Define CONV_POOL_RELU_EN to clamp negative saturated conv results to zero before pooling.
module conv_pool_engine #(
  parameter int IMG_DIM = 28,
  parameter int PIX_W   = 8,
  parameter int KER_W   = 8,
  parameter int ACC_W   = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    reuse_kernel,
  input  logic                    ker_valid,
  output logic                    ker_ready,
  input  logic signed [KER_W-1:0] ker_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic        [PIX_W-1:0] pix_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);
  localparam int C     = IMG_DIM - 2;
  localparam int P     = C / 2;
  localparam int NPIX  = IMG_DIM * IMG_DIM;
  localparam int NCONV = C * C;
  localparam int SW    = PIX_W + KER_W + 5;
  localparam int XW    = (SW > ACC_W) ? SW : ACC_W;
  localparam int IW    = $clog2(NPIX);
  localparam int CIW   = $clog2(NCONV);
  localparam int CW    = $clog2(C);

  localparam logic [CW-1:0] C_LAST = CW'(C - 1);
  localparam logic [CW-1:0] P_LAST = CW'(P - 1);
  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_KER, LOAD_IMG, CONV, POOL, DONE} state_t;

  state_t                  r_state, w_next;
  logic [IW-1:0]           r_lcnt;
  logic [CW-1:0]           r_row, r_col, r_prow, r_pcol;
  logic signed [KER_W-1:0] r_ker  [9];
  logic        [PIX_W-1:0] r_img  [NPIX];
  logic signed [ACC_W-1:0] r_conv [NCONV];

  logic                    w_ker_end, w_pix_end, w_conv_end, w_pool_last;
  logic signed [XW-1:0]    w_sum, w_pe, w_ke;
  logic signed [ACC_W-1:0] w_sat, w_conv_val, w_pool_max;
  logic signed [ACC_W-1:0] w_p00, w_p01, w_p10, w_p11;
  logic [CIW-1:0]          w_cidx, w_pidx;

  assign w_ker_end   = (r_lcnt == IW'(8));
  assign w_pix_end   = (r_lcnt == IW'(NPIX - 1));
  assign w_conv_end  = (r_row == C_LAST) && (r_col == C_LAST);
  assign w_pool_last = (r_prow == P_LAST) && (r_pcol == P_LAST);
  assign w_cidx      = CIW'(32'(r_row) * C + 32'(r_col));
  assign w_pidx      = CIW'(2 * 32'(r_prow) * C + 2 * 32'(r_pcol));

  // Window sum is formed at full product width; saturation happens only once at the end.
  always_comb begin
    w_sum = '0;
    w_pe  = '0;
    w_ke  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        w_pe  = $signed({{(XW-PIX_W){1'b0}},
                         r_img[IW'((32'(r_row) + i) * IMG_DIM + 32'(r_col) + j)]});
        w_ke  = {{(XW-KER_W){r_ker[4'(i*3 + j)][KER_W-1]}}, r_ker[4'(i*3 + j)]};
        w_sum = w_sum + w_pe * w_ke;
      end
    end
  end

  always_comb begin
    if (w_sum > SAT_MAX)      w_sat = {1'b0, {(ACC_W-1){1'b1}}};
    else if (w_sum < SAT_MIN) w_sat = {1'b1, {(ACC_W-1){1'b0}}};
    else                      w_sat = w_sum[ACC_W-1:0];
`ifdef CONV_POOL_RELU_EN
    w_conv_val = w_sat[ACC_W-1] ? '0 : w_sat;
`else
    w_conv_val = w_sat;
`endif
  end

  always_comb begin
    w_p00      = r_conv[w_pidx];
    w_p01      = r_conv[w_pidx + CIW'(1)];
    w_p10      = r_conv[w_pidx + CIW'(C)];
    w_p11      = r_conv[w_pidx + CIW'(C + 1)];
    w_pool_max = w_p00;
    if (w_p01 > w_pool_max) w_pool_max = w_p01;
    if (w_p10 > w_pool_max) w_pool_max = w_p10;
    if (w_p11 > w_pool_max) w_pool_max = w_p11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = reuse_kernel ? LOAD_IMG : LOAD_KER;
      LOAD_KER: if (ker_valid && w_ker_end) w_next = LOAD_IMG;
      LOAD_IMG: if (pix_valid && w_pix_end) w_next = CONV;
      CONV:     if (w_conv_end) w_next = POOL;
      POOL:     if (out_ready && w_pool_last) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    ker_ready = (r_state == LOAD_KER);
    pix_ready = (r_state == LOAD_IMG);
    out_valid = (r_state == POOL);
    out_last  = (r_state == POOL) && w_pool_last;
    out_data  = (r_state == POOL) ? w_pool_max : '0;
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcnt <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_prow <= '0;
      r_pcol <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_lcnt <= '0;
          r_row  <= '0;
          r_col  <= '0;
          r_prow <= '0;
          r_pcol <= '0;
        end
        LOAD_KER: if (ker_valid) r_lcnt <= w_ker_end ? '0 : r_lcnt + 1'b1;
        LOAD_IMG: if (pix_valid) r_lcnt <= r_lcnt + 1'b1;
        CONV: begin
          if (r_col == C_LAST) begin
            r_col <= '0;
            r_row <= w_conv_end ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        POOL: begin
          if (out_ready) begin
            if (r_pcol == P_LAST) begin
              r_pcol <= '0;
              r_prow <= w_pool_last ? '0 : r_prow + 1'b1;
            end else begin
              r_pcol <= r_pcol + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; their contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (r_state == LOAD_KER && ker_valid) r_ker[r_lcnt[3:0]] <= ker_data;
    if (r_state == LOAD_IMG && pix_valid) r_img[r_lcnt]      <= pix_data;
    if (r_state == CONV)                  r_conv[w_cidx]     <= w_conv_val;
  end
endmodule
